// File: rtl/ppr_test_pkg.sv
// Shared types and default constants for the PPR encoder test sequencer.
package ppr_test_pkg;

    localparam int unsigned PPR_DEFAULT     = 2048;
    localparam int unsigned GAP_DEFAULT     = 4;
    localparam int unsigned CNT_W_DEFAULT   = 16;
    localparam int unsigned REV_W_DEFAULT   = 8;
    localparam int unsigned TIMEOUT_DEFAULT = 1000000;

    typedef enum logic [2:0] {
        IDLE,
        START,
        WAIT_Z0,
        COUNT,
        GAP_WAIT,
        FINISH
    } seq_state_e;

endpackage

// File: rtl/rise_detect.sv
// Registered 1-bit rising-edge detector; the pulse appears one cycle after
// the input is first sampled high.
module rise_detect (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic rise
);

    logic d_q, d_d;
    logic rise_q, rise_d;

    always_comb begin
        d_d    = d;
        rise_d = d & ~d_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            d_q    <= 1'b0;
            rise_q <= 1'b0;
        end else begin
            d_q    <= d_d;
            rise_q <= rise_d;
        end
    end

    assign rise = rise_q;

endmodule

// File: rtl/ppr_test_sequencer.sv
// Test controller for the PPR encoder simulator: starts revolutions and counts
// A edges between Z markers. Define SEQ_INPUT_SYNC_EN to synchronize AIn/ZIn.
module ppr_test_sequencer
    import ppr_test_pkg::*;
#(
    parameter int unsigned PPR     = PPR_DEFAULT,
    parameter int unsigned CNT_W   = CNT_W_DEFAULT,
    parameter int unsigned REV_W   = REV_W_DEFAULT,
    parameter int unsigned GAP     = GAP_DEFAULT,
    parameter int unsigned TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Go,
    input  logic [REV_W-1:0] RevCount,
    output logic             SimStart,
    input  logic             AIn,
    input  logic             ZIn,
    output logic             Busy,
    output logic             Done,
    output logic             Pass,
    output logic [REV_W-1:0] ErrCount,
    output logic [CNT_W-1:0] LastCount,
    output logic             Timeout
);

    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned GAP_W = (GAP > 1) ? $clog2(GAP) : 1;

    logic a_src, z_src;
    logic go_rise, a_rise, z_rise;

`ifdef SEQ_INPUT_SYNC_EN
    // Two-flop synchronizers for inputs arriving from a real encoder.
    logic [1:0] a_sync_q, a_sync_d;
    logic [1:0] z_sync_q, z_sync_d;

    always_comb begin
        a_sync_d = {a_sync_q[0], AIn};
        z_sync_d = {z_sync_q[0], ZIn};
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            a_sync_q <= 2'b00;
            z_sync_q <= 2'b00;
        end else begin
            a_sync_q <= a_sync_d;
            z_sync_q <= z_sync_d;
        end
    end

    assign a_src = a_sync_q[1];
    assign z_src = z_sync_q[1];
`else
    assign a_src = AIn;
    assign z_src = ZIn;
`endif

    rise_detect u_go_rise (.clk(Clk), .rst(Rst), .d(Go),    .rise(go_rise));
    rise_detect u_a_rise  (.clk(Clk), .rst(Rst), .d(a_src), .rise(a_rise));
    rise_detect u_z_rise  (.clk(Clk), .rst(Rst), .d(z_src), .rise(z_rise));

    seq_state_e       state_q, state_d;
    logic [REV_W-1:0] rev_left_q, rev_left_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TO_W-1:0]  tcnt_q, tcnt_d;
    logic [GAP_W-1:0] gcnt_q, gcnt_d;
    logic             simstart_q, simstart_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;
    logic [REV_W-1:0] err_cnt_q, err_cnt_d;
    logic [CNT_W-1:0] last_cnt_q, last_cnt_d;
    logic             timeout_q, timeout_d;

    logic [CNT_W-1:0] cnt_inc;
    logic [CNT_W-1:0] rev_total;
    logic [REV_W-1:0] err_inc;
    logic             to_hit;

    // Saturating helpers; rev_total folds in an A edge coincident with Z.
    always_comb begin
        cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
        rev_total = a_rise ? cnt_inc : cnt_q;
        err_inc   = (err_cnt_q == '1) ? err_cnt_q : err_cnt_q + REV_W'(1);
        to_hit    = (tcnt_q == TO_W'(TIMEOUT));
    end

    always_comb begin
        state_d    = state_q;
        rev_left_d = rev_left_q;
        cnt_d      = cnt_q;
        tcnt_d     = tcnt_q;
        gcnt_d     = gcnt_q;
        pass_d     = pass_q;
        err_cnt_d  = err_cnt_q;
        last_cnt_d = last_cnt_q;
        timeout_d  = timeout_q;

        case (state_q)
            IDLE: begin
                if (go_rise) begin
                    rev_left_d = (RevCount == '0) ? REV_W'(1) : RevCount;
                    err_cnt_d  = '0;
                    pass_d     = 1'b0;
                    timeout_d  = 1'b0;
                    state_d    = START;
                end
            end
            START: begin
                cnt_d   = '0;
                tcnt_d  = '0;
                state_d = WAIT_Z0;
            end
            WAIT_Z0: begin
                if (z_rise) begin
                    tcnt_d  = '0;
                    state_d = COUNT;
                end else if (to_hit) begin
                    timeout_d = 1'b1;
                    err_cnt_d = err_inc;
                    state_d   = FINISH;
                end else begin
                    tcnt_d = tcnt_q + TO_W'(1);
                end
            end
            COUNT: begin
                cnt_d = rev_total;
                if (z_rise) begin
                    tcnt_d     = '0;
                    gcnt_d     = '0;
                    last_cnt_d = rev_total;
                    if (rev_total != CNT_W'(PPR)) begin
                        err_cnt_d = err_inc;
                    end
                    rev_left_d = rev_left_q - REV_W'(1);
                    state_d    = GAP_WAIT;
                end else if (to_hit) begin
                    timeout_d = 1'b1;
                    err_cnt_d = err_inc;
                    state_d   = FINISH;
                end else begin
                    tcnt_d = tcnt_q + TO_W'(1);
                end
            end
            GAP_WAIT: begin
                if (gcnt_q == GAP_W'(GAP - 1)) begin
                    state_d = (rev_left_q == '0) ? FINISH : START;
                end else begin
                    gcnt_d = gcnt_q + GAP_W'(1);
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Strobes are registered so they line up with the state they flag.
        simstart_d = (state_d == START);
        done_d     = (state_d == FINISH);
        busy_d     = (state_d != IDLE) && (state_d != FINISH);
        if (state_d == FINISH) begin
            pass_d = (err_cnt_d == '0) && !timeout_d;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= IDLE;
            rev_left_q <= '0;
            cnt_q      <= '0;
            tcnt_q     <= '0;
            gcnt_q     <= '0;
            simstart_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
            err_cnt_q  <= '0;
            last_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rev_left_q <= rev_left_d;
            cnt_q      <= cnt_d;
            tcnt_q     <= tcnt_d;
            gcnt_q     <= gcnt_d;
            simstart_q <= simstart_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
            err_cnt_q  <= err_cnt_d;
            last_cnt_q <= last_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    assign SimStart  = simstart_q;
    assign Busy      = busy_q;
    assign Done      = done_q;
    assign Pass      = pass_q;
    assign ErrCount  = err_cnt_q;
    assign LastCount = last_cnt_q;
    assign Timeout   = timeout_q;

endmodule

// File: tb/tb_ppr_test_sequencer.sv
// Bench for ppr_test_sequencer: an encoder model drives A/Z per revolution and
// run results are compared with expectations derived from the per-rev A counts.
module tb_ppr_test_sequencer;

    localparam int unsigned PPR      = 2048;
    localparam int unsigned CNT_W    = 16;
    localparam int unsigned REV_W    = 8;
    localparam int unsigned GAP      = 4;
    localparam int unsigned TO_MAIN  = 6000;
    localparam int unsigned TO_SHORT = 100;

    logic             clk = 1'b0;
    logic             rst;
    logic             go;
    logic [REV_W-1:0] rev_count;
    logic             a_in;
    logic             z_in;

    logic             sim_start, busy, done, pass, timeout;
    logic [REV_W-1:0] err_count;
    logic [CNT_W-1:0] last_count;

    logic             to_sim_start, to_busy, to_done, to_pass, to_timeout;
    logic [REV_W-1:0] to_err_count;
    logic [CNT_W-1:0] to_last_count;

    int n_checks = 0;
    int n_errors = 0;
    int simstart_cnt = 0;
    int done_cnt = 0;

    int rev_a [8];
    bit rev_co [8];

    always #5 clk = ~clk;

    ppr_test_sequencer #(
        .PPR(PPR), .CNT_W(CNT_W), .REV_W(REV_W), .GAP(GAP), .TIMEOUT(TO_MAIN)
    ) u_dut (
        .Clk(clk), .Rst(rst), .Go(go), .RevCount(rev_count), .SimStart(sim_start),
        .AIn(a_in), .ZIn(z_in), .Busy(busy), .Done(done), .Pass(pass),
        .ErrCount(err_count), .LastCount(last_count), .Timeout(timeout)
    );

    // Second instance never sees Z, so every run it starts must time out.
    ppr_test_sequencer #(
        .PPR(PPR), .CNT_W(CNT_W), .REV_W(REV_W), .GAP(GAP), .TIMEOUT(TO_SHORT)
    ) u_dut_to (
        .Clk(clk), .Rst(rst), .Go(go), .RevCount(rev_count), .SimStart(to_sim_start),
        .AIn(a_in), .ZIn(1'b0), .Busy(to_busy), .Done(to_done), .Pass(to_pass),
        .ErrCount(to_err_count), .LastCount(to_last_count), .Timeout(to_timeout)
    );

    always @(negedge clk) begin
        if (sim_start) simstart_cnt <= simstart_cnt + 1;
        if (done)      done_cnt     <= done_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_simstart(input int target, input string tag);
        int b = 0;
        while (simstart_cnt < target && b < 300) begin
            tick();
            b++;
        end
        check_eq({tag, "_simstart_seen"}, 64'(simstart_cnt >= target), 64'(1));
    endtask

    // One revolution: start Z, n A pulses, end Z (optionally on the last A edge).
    task automatic emit_rev(input int n, input bit co);
        tick(3);
        z_in = 1'b1; tick(); z_in = 1'b0; tick(2);
        for (int i = 0; i < n; i++) begin
            a_in = 1'b1;
            if (co && i == n - 1) z_in = 1'b1;
            tick();
            a_in = 1'b0;
            z_in = 1'b0;
            tick();
        end
        if (!co) begin
            tick(); z_in = 1'b1; tick(); z_in = 1'b0;
        end
        tick();
    endtask

    task automatic do_run(input int rc, input bit extra_go, input string tag);
        int nrev, ss0, dn0, exp_err, b;
        nrev = (rc == 0) ? 1 : rc;
        ss0  = simstart_cnt;
        dn0  = done_cnt;
        rev_count = REV_W'(rc);
        go = 1'b1;
        tick();
        check_eq({tag, "_simstart_early"}, 64'(sim_start), 64'(0));
        tick();
        check_eq({tag, "_simstart_lat2"}, 64'(sim_start), 64'(1));
        go = 1'b0;
        for (int r = 0; r < nrev; r++) begin
            wait_simstart(ss0 + r + 1, tag);
            if (r == 0 && extra_go) begin
                go = 1'b1; tick(2); go = 1'b0;
            end
            emit_rev(rev_a[r], rev_co[r]);
            check_eq({tag, "_busy_mid"}, 64'(busy), 64'(1));
        end
        b = 0;
        while (done_cnt == dn0 && b < 300) begin
            tick();
            b++;
        end
        tick(5);
        exp_err = 0;
        for (int r = 0; r < nrev; r++) begin
            if (rev_a[r] != int'(PPR)) exp_err++;
        end
        if (exp_err > 255) exp_err = 255;
        check_eq({tag, "_done_pulses"}, 64'(done_cnt - dn0), 64'(1));
        check_eq({tag, "_simstart_pulses"}, 64'(simstart_cnt - ss0), 64'(nrev));
        check_eq({tag, "_busy_end"}, 64'(busy), 64'(0));
        check_eq({tag, "_pass"}, 64'(pass), 64'(exp_err == 0));
        check_eq({tag, "_errcount"}, 64'(err_count), 64'(exp_err));
        check_eq({tag, "_lastcount"}, 64'(last_count), 64'(rev_a[nrev - 1]));
        check_eq({tag, "_timeout"}, 64'(timeout), 64'(0));
    endtask

    task automatic test_timeout();
        int t_ss, t_dn, ss_n, dn_n, lat;
        t_ss = -1; t_dn = -1; ss_n = 0; dn_n = 0;
        rev_count = REV_W'(3);
        go = 1'b1;
        for (int c = 0; c < 400; c++) begin
            tick();
            if (c == 2) go = 1'b0;
            if (to_sim_start) begin
                ss_n++;
                if (t_ss < 0) t_ss = c;
            end
            if (to_done) begin
                dn_n++;
                if (t_dn < 0) t_dn = c;
            end
        end
        lat = t_dn - t_ss;
        check_eq($sformatf("to_latency_%0d_in_101_102", lat),
                 64'(t_ss >= 0 && t_dn >= 0 && lat >= 101 && lat <= 102), 64'(1));
        check_eq("to_simstart_pulses", 64'(ss_n), 64'(1));
        check_eq("to_done_pulses", 64'(dn_n), 64'(1));
        check_eq("to_timeout", 64'(to_timeout), 64'(1));
        check_eq("to_pass", 64'(to_pass), 64'(0));
        check_eq("to_errcount", 64'(to_err_count), 64'(1));
        check_eq("to_busy", 64'(to_busy), 64'(0));
        // Main instance is still waiting for Z; reset clears both.
        rst = 1'b1; tick(); rst = 1'b0;
        check_eq("to_rst_busy", 64'(busy), 64'(0));
        check_eq("to_rst_timeout", 64'(to_timeout), 64'(0));
        check_eq("to_rst_errcount", 64'(to_err_count), 64'(0));
        tick(2);
    endtask

    task automatic test_reset_mid();
        int d0;
        rev_count = REV_W'(2);
        go = 1'b1; tick(2); go = 1'b0;
        wait_simstart(simstart_cnt + 1, "rstmid");
        tick(3);
        z_in = 1'b1; tick(); z_in = 1'b0; tick(2);
        for (int i = 0; i < 1000; i++) begin
            a_in = 1'b1; tick(); a_in = 1'b0; tick();
        end
        check_eq("rstmid_busy_before", 64'(busy), 64'(1));
        d0 = done_cnt;
        rst = 1'b1;
        tick();
        check_eq("rstmid_busy", 64'(busy), 64'(0));
        check_eq("rstmid_errcount", 64'(err_count), 64'(0));
        check_eq("rstmid_lastcount", 64'(last_count), 64'(0));
        check_eq("rstmid_done", 64'(done), 64'(0));
        rst = 1'b0;
        tick(30);
        check_eq("rstmid_no_done", 64'(done_cnt - d0), 64'(0));
        check_eq("rstmid_idle_busy", 64'(busy), 64'(0));
    endtask

    initial begin
        rst = 1'b1; go = 1'b0; a_in = 1'b0; z_in = 1'b0; rev_count = '0;
        tick(3);
        check_eq("rst_simstart", 64'(sim_start), 64'(0));
        check_eq("rst_busy", 64'(busy), 64'(0));
        check_eq("rst_done", 64'(done), 64'(0));
        check_eq("rst_pass", 64'(pass), 64'(0));
        check_eq("rst_errcount", 64'(err_count), 64'(0));
        check_eq("rst_lastcount", 64'(last_count), 64'(0));
        check_eq("rst_timeout", 64'(timeout), 64'(0));
        rst = 1'b0;
        tick(2);

        for (int r = 0; r < 3; r++) begin rev_a[r] = int'(PPR); rev_co[r] = 1'b0; end
        do_run(3, 1'b0, "nominal");

        rev_a[1] = int'(PPR) - 1;
        do_run(3, 1'b0, "miscount");

        test_timeout();

        rev_a[0] = int'(PPR); rev_co[0] = 1'b1;
        do_run(1, 1'b0, "coincident");

        rev_co[0] = 1'b0;
        do_run(0, 1'b1, "gobusy_rc0");

        test_reset_mid();
        rev_a[0] = int'(PPR); rev_co[0] = 1'b0;
        do_run(1, 1'b0, "fresh");

        for (int k = 0; k < 2; k++) begin
            int rc;
            rc = int'($urandom_range(2, 1));
            for (int r = 0; r < rc; r++) begin
                rev_a[r] = int'(PPR);
                if ($urandom_range(2, 0) == 0) rev_a[r] = int'(PPR) - 2 + int'($urandom_range(4, 0));
                rev_co[r] = 1'($urandom_range(1, 0));
            end
            do_run(rc, 1'b0, $sformatf("rand%0d", k));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1500000;
        $display("FAIL watchdog: run exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
